// File: rtl/embeddedcpu_hex_pkg.sv
// rtl/embeddedcpu_hex_pkg.sv - register offsets and glyph table for the hex display bank
//
// Purpose: shared constants for embeddedcpu_hex_bank and hex_seg_decode.
//   HEX_REG_*  : word offsets of the slave registers.
//   HEX_GLYPH  : active-high 7-segment glyphs for nibbles 0..F (bit0=a .. bit6=g).
package embeddedcpu_hex_pkg;

  localparam logic [3:0] HEX_REG_DATA0  = 4'h0;
  localparam logic [3:0] HEX_REG_DECODE = 4'h8;
  localparam logic [3:0] HEX_REG_BLINK  = 4'h9;
  localparam logic [3:0] HEX_REG_BLANK  = 4'hA;
  localparam logic [3:0] HEX_REG_PACKED = 4'hB;
  localparam logic [3:0] HEX_REG_STATUS = 4'hC;

  localparam logic [6:0] HEX_GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/embeddedcpu_hex_bank_if.sv
// rtl/embeddedcpu_hex_bank_if.sv - Avalon-MM slave bus bundle for the hex display bank
//
// Purpose: groups the register bus of embeddedcpu_hex_bank.
//   address[3:0]    word address          (master -> slave)
//   chipselect      slave select          (master -> slave)
//   write_n         active-low write      (master -> slave)
//   writedata[31:0] write data            (master -> slave)
//   readdata[31:0]  combinational read    (slave -> master)
interface embeddedcpu_hex_bank_if;

  logic [3:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);

endinterface

// File: rtl/hex_seg_decode.sv
// rtl/hex_seg_decode.sv - nibble to active-high 7-segment glyph
//
// Purpose: combinational hex glyph lookup.
//   nibble[3:0] in  : value 0..F
//   seg[6:0]    out : segments, bit0=a .. bit6=g, active-high
module hex_seg_decode
  import embeddedcpu_hex_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = HEX_GLYPH[nibble];

endmodule

// File: rtl/embeddedcpu_hex_bank.sv
// rtl/embeddedcpu_hex_bank.sv - multi-digit seven-segment display controller slave
//
// Purpose: per-digit data registers with hex decode, raw mode, blanking and a
// hardware blink timer, driving NUM_DIGITS registered segment outputs.
//   clk           in  : system clock
//   reset_n       in  : asynchronous active-low reset
//   bus           slv : register bus (embeddedcpu_hex_bank_if.slave)
//   hex_out       out : digit i on bits [8i+7:8i], bit0=a .. bit6=g, bit7=dp
module embeddedcpu_hex_bank
  import embeddedcpu_hex_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter int BLINK_DIV  = 25_000_000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  embeddedcpu_hex_bank_if.slave   bus,
  output logic [8*NUM_DIGITS-1:0] hex_out
);

  localparam int             CW      = $clog2(BLINK_DIV);
  localparam logic [CW-1:0]  CNT_MAX = CW'(BLINK_DIV - 1);
  localparam logic [7:0]     POL     = ACTIVE_LOW ? 8'hFF : 8'h00;

  logic [7:0]              data_q [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]   decode_q, blink_q, blank_q;
  logic [CW-1:0]           cnt_q;
  logic                    phase_q;
  logic [8*NUM_DIGITS-1:0] hex_d;
  logic [31:0]             rdata;
  logic                    wr;
  logic                    unused_wdata;

  assign wr           = bus.chipselect && !bus.write_n;
  assign unused_wdata = ^bus.writedata;

  // Register file; PACKED overwrites every data register's low nibble and clears the rest.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_DIGITS; i++) data_q[i] <= '0;
      decode_q <= '0;
      blink_q  <= '0;
      blank_q  <= '0;
    end else if (wr) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (bus.address == HEX_REG_DATA0 + 4'(i))
          data_q[i] <= bus.writedata[7:0];
        else if (bus.address == HEX_REG_PACKED)
          data_q[i] <= {4'b0, bus.writedata[4*i +: 4]};
      end
      case (bus.address)
        HEX_REG_DECODE: decode_q <= bus.writedata[NUM_DIGITS-1:0];
        HEX_REG_BLINK:  blink_q  <= bus.writedata[NUM_DIGITS-1:0];
        HEX_REG_BLANK:  blank_q  <= bus.writedata[NUM_DIGITS-1:0];
        default: ;
      endcase
    end
  end

  // Blink timer; any BLINK write restarts the cycle and wins over a wrap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else if (wr && bus.address == HEX_REG_BLINK) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_q   <= '0;
      phase_q <= ~phase_q;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  always_comb begin
    rdata = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bus.address == HEX_REG_DATA0 + 4'(i)) rdata = {24'b0, data_q[i]};
    end
    case (bus.address)
      HEX_REG_DECODE: rdata = 32'(decode_q);
      HEX_REG_BLINK:  rdata = 32'(blink_q);
      HEX_REG_BLANK:  rdata = 32'(blank_q);
      HEX_REG_PACKED: for (int i = 0; i < NUM_DIGITS; i++) rdata[4*i +: 4] = data_q[i][3:0];
      HEX_REG_STATUS: rdata = {31'b0, phase_q};
      default: ;
    endcase
  end

  assign bus.readdata = rdata;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    logic [6:0] glyph;
    logic [7:0] seg;

    hex_seg_decode u_dec (
      .nibble (data_q[g][3:0]),
      .seg    (glyph)
    );

    // Blank beats blink, blink beats content; polarity applied last.
    always_comb begin
      if (blank_q[g])                 seg = 8'h00;
      else if (blink_q[g] && phase_q) seg = 8'h00;
      else if (decode_q[g])           seg = {data_q[g][7], glyph};
      else                            seg = data_q[g];
    end

    assign hex_d[8*g +: 8] = seg ^ POL;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) hex_out <= {NUM_DIGITS{POL}};
    else          hex_out <= hex_d;
  end

endmodule
